instruction_sequencer: RTL
==========================

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: ready  input  1  high = advance; low = hold all sequencing state.
REQ-004 SHALL have port: addressTimingCode  input  3  address-phase cycle count from the decoder, sampled in FETCH.
REQ-005 SHALL have port: opTimingCode  input  3  operation-phase cycle count from the decoder, sampled in FETCH.
REQ-006 SHALL have port: page_cross  input  1  indexed address crossed a page; sampled on the last ADDR step.
REQ-007 SHALL have port: irq  input  1  maskable interrupt request, level.
REQ-008 SHALL have port: irq_mask  input  1  I flag; 1 blocks irq.
REQ-009 SHALL have port: nmi  input  1  non-maskable request, rising-edge sensitive.
REQ-010 SHALL have port: seq_state  output  3  current state (package enum).
REQ-011 SHALL have port: step  output  3  cycle index within the current state.
REQ-012 SHALL have port: sync  output  1  high during the opcode-fetch cycle.
REQ-013 SHALL have port: instr_done  output  1  high on the final OP cycle.
REQ-014 SHALL have port: int_active  output  1  high throughout the INT sequence.
REQ-015 SHALL have port: int_is_nmi  output  1  current or last INT sequence serves NMI.

Function
REQ-016 SHALL implement states RESET_SEQ, FETCH, ADDR, FIXUP, OP, INT; step SHALL be 0 on every state entry and increment by 1 per advancing cycle.
REQ-017 RESET_SEQ SHALL last 7 advancing cycles (step 0..6), then go to FETCH.
REQ-018 FETCH SHALL last 1 cycle with sync=1, latch both timing codes, then go to ADDR if addressTimingCode != 0, else OP.
REQ-019 ADDR SHALL last addr_cycles cycles (step 0..n-1); on the last step go to FIXUP if page_cross=1, else OP.
REQ-020 FIXUP SHALL last exactly 1 cycle, then go to OP.
REQ-021 OP SHALL last op_cycles cycles; a latched opTimingCode of 0 SHALL be treated as 1.
REQ-022 On the last OP step, instr_done SHALL be 1; next state SHALL be INT if nmi_pending, or if irq=1 and irq_mask=0; otherwise FETCH.
REQ-023 INT SHALL last 7 cycles with int_active=1, then go to FETCH; int_is_nmi SHALL be set on INT entry (NMI has priority over IRQ) and hold until the next INT entry.
REQ-024 nmi_pending SHALL set on a 0->1 transition of registered nmi and clear on INT entry for NMI; if set and clear coincide, set SHALL win.
REQ-025 The nmi edge detector SHALL run regardless of ready; all other registers SHALL hold while ready=0.
REQ-026 sync, instr_done and int_active SHALL be decoded from the registered state/step, with no combinational path from inputs.
REQ-027 irq SHALL be sampled only on the last OP step; irq pulses at other times SHALL be ignored.

Reset
REQ-028 rst=1 SHALL override ready and every event, and force: seq_state=RESET_SEQ, step=0, sync=0, instr_done=0, int_active=0, int_is_nmi=0, nmi_pending=0, nmi history=0, latched codes=0.
REQ-029 rst asserted mid-instruction or mid-INT SHALL abort the sequence at the next edge.

Structure
REQ-030 The seq_state enum and constants RESET_CYCLES=7 and INT_CYCLES=7 SHALL live in the shared CPU package alongside the decoder's command/address enums.
REQ-031 The nmi edge detector + pending latch SHALL be one sub-module, nmi_edge_latch; the rest SHALL be flat.

Verification
REQ-032 After rst: 7 cycles RESET_SEQ, then sync=1 on cycle 8.
REQ-033 Codes addr=2, op=1, page_cross=0 -> FETCH, ADDR x2, OP x1; instr_done 4 cycles after sync; sync again on cycle 5.
REQ-034 Same codes with page_cross=1 on the last ADDR step -> one FIXUP cycle inserted; instr_done at cycle 5.
REQ-035 ready=0 for 3 cycles mid-ADDR -> seq_state/step frozen; sequence resumes, with total length extended by exactly 3 cycles.
REQ-036 irq=1 with irq_mask=0, plus an nmi rise in the same instruction -> INT entered with int_is_nmi=1; nmi_pending cleared; irq serviced after the next instruction.
REQ-037 irq_mask=1 -> no INT; addr=0 -> FETCH goes straight to OP; rst during OP -> RESET_SEQ on the next cycle.

Source files
------------

// File: rtl/instruction_sequencer_pkg.sv
// Shared CPU package: sequencer state encoding, sequence lengths, and the
// decoder's command/address-mode enums. No ports; imported by the
// sequencer interface, the sequencer top and the bench.
package instruction_sequencer_pkg;

  // Sequencer state as seen on seq_state.
  typedef enum logic [2:0] {
    SEQ_RESET = 3'd0,
    SEQ_FETCH = 3'd1,
    SEQ_ADDR  = 3'd2,
    SEQ_FIXUP = 3'd3,
    SEQ_OP    = 3'd4,
    SEQ_INT   = 3'd5
  } seq_state_e;

  // Legacy-compatible state constants used inside the FSM; values match seq_state_e.
  localparam logic [2:0] ST_RESET_SEQ = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_ADDR      = 3'd2;
  localparam logic [2:0] ST_FIXUP     = 3'd3;
  localparam logic [2:0] ST_OP        = 3'd4;
  localparam logic [2:0] ST_INT       = 3'd5;

  // Fixed sequence lengths in advancing cycles.
  localparam logic [2:0] RESET_CYCLES = 3'd7;
  localparam logic [2:0] INT_CYCLES   = 3'd7;

  // Decoder command class.
  typedef enum logic [1:0] {
    CMD_NOP   = 2'd0,
    CMD_READ  = 2'd1,
    CMD_WRITE = 2'd2,
    CMD_RMW   = 2'd3
  } cmd_e;

  // Decoder addressing mode.
  typedef enum logic [2:0] {
    AM_IMPLIED  = 3'd0,
    AM_IMMED    = 3'd1,
    AM_ZPAGE    = 3'd2,
    AM_ABSOLUTE = 3'd3,
    AM_INDEXED  = 3'd4,
    AM_INDIRECT = 3'd5
  } addr_mode_e;

  // An operation-phase code of zero still takes one cycle.
  function automatic logic [2:0] op_cycles_f(input logic [2:0] code);
    logic [2:0] cycles;
    if (code == 3'd0) begin
      cycles = 3'd1;
    end else begin
      cycles = code;
    end
    return cycles;
  endfunction

endpackage

// File: rtl/instruction_sequencer_if.sv
// Sequencer bus interface.
// master: decoder/interrupt side; drives ready, timing codes, page_cross,
//         irq, irq_mask, nmi; observes the sequencer status outputs.
// slave : the sequencer; consumes those inputs and drives seq_state, step,
//         sync, instr_done, int_active, int_is_nmi.
interface instruction_sequencer_if;
  import instruction_sequencer_pkg::*;

  logic       ready;
  logic [2:0] addressTimingCode;
  logic [2:0] opTimingCode;
  logic       page_cross;
  logic       irq;
  logic       irq_mask;
  logic       nmi;

  seq_state_e seq_state;
  logic [2:0] step;
  logic       sync;
  logic       instr_done;
  logic       int_active;
  logic       int_is_nmi;

  modport master (
    output ready, addressTimingCode, opTimingCode, page_cross, irq, irq_mask, nmi,
    input  seq_state, step, sync, instr_done, int_active, int_is_nmi
  );

  modport slave (
    input  ready, addressTimingCode, opTimingCode, page_cross, irq, irq_mask, nmi,
    output seq_state, step, sync, instr_done, int_active, int_is_nmi
  );
endinterface

// File: rtl/instruction_sequencer_nmi_edge_latch.sv
// NMI edge detector and pending latch. The pin is registered twice; a 0->1
// step between the two registered copies sets the pending flag. Runs every
// clock, independent of the sequencer's ready stall.
// Ports: clk, rst (sync, active-high), i_nmi (raw request), i_clear (INT
// entry that serves NMI), o_pending (NMI awaiting service).
module nmi_edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic i_nmi,
  input  logic i_clear,
  output logic o_pending
);

  logic r_nmi_q1;
  logic r_nmi_q2;
  logic r_pending;
  logic w_rise;

  assign w_rise    = r_nmi_q1 & ~r_nmi_q2;
  assign o_pending = r_pending;

  // NMI history and pending flag; a new edge beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_nmi_q1  <= 1'b0;
      r_nmi_q2  <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_nmi_q1 <= i_nmi;
      r_nmi_q2 <= r_nmi_q1;
      if (w_rise) begin
        r_pending <= 1'b1;
      end else if (i_clear) begin
        r_pending <= 1'b0;
      end else begin
        r_pending <= r_pending;
      end
    end
  end

endmodule

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: walks RESET_SEQ -> FETCH -> [ADDR -> [FIXUP]] ->
// OP -> (FETCH | INT) with a per-state step counter, stalling on ready=0.
// Ports: clk, rst (sync, active-high), bus (slave modport): ready, timing
// codes, page_cross, irq/irq_mask, nmi in; seq_state, step, sync,
// instr_done, int_active, int_is_nmi out. Status outputs are decoded only
// from registered state.
module instruction_sequencer
  import instruction_sequencer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  instruction_sequencer_if.slave bus
);

  logic [2:0] r_state;
  logic [2:0] r_step;
  logic [2:0] r_addr_code;
  logic [2:0] r_op_code;
  logic       r_int_is_nmi;

  logic [2:0] w_next_state;
  logic       w_state_done;
  logic       w_op_last;
  logic       w_int_req;
  logic       w_enter_int;
  logic       w_nmi_clear;
  logic       w_nmi_pending;

  nmi_edge_latch u_nmi (
    .clk      (clk),
    .rst      (rst),
    .i_nmi    (bus.nmi),
    .i_clear  (w_nmi_clear),
    .o_pending(w_nmi_pending)
  );

  assign w_op_last   = (r_step == (op_cycles_f(r_op_code) - 3'd1));
  assign w_int_req   = w_nmi_pending | (bus.irq & ~bus.irq_mask);
  // irq/nmi are only consulted here, on an advancing last OP step.
  assign w_enter_int = bus.ready & (r_state == ST_OP) & w_op_last & w_int_req;
  assign w_nmi_clear = w_enter_int & w_nmi_pending;

  // Last-step detection and successor state for the current state.
  always_comb begin
    w_next_state = r_state;
    w_state_done = 1'b0;
    case (r_state)
      ST_RESET_SEQ: begin
        w_state_done = (r_step == (RESET_CYCLES - 3'd1));
        w_next_state = ST_FETCH;
      end
      ST_FETCH: begin
        w_state_done = 1'b1;
        if (bus.addressTimingCode != 3'd0) begin
          w_next_state = ST_ADDR;
        end else begin
          w_next_state = ST_OP;
        end
      end
      ST_ADDR: begin
        w_state_done = (r_step == (r_addr_code - 3'd1));
        if (bus.page_cross) begin
          w_next_state = ST_FIXUP;
        end else begin
          w_next_state = ST_OP;
        end
      end
      ST_FIXUP: begin
        w_state_done = 1'b1;
        w_next_state = ST_OP;
      end
      ST_OP: begin
        w_state_done = w_op_last;
        if (w_int_req) begin
          w_next_state = ST_INT;
        end else begin
          w_next_state = ST_FETCH;
        end
      end
      ST_INT: begin
        w_state_done = (r_step == (INT_CYCLES - 3'd1));
        w_next_state = ST_FETCH;
      end
      default: begin
        // Unreachable encodings recover through a full reset sequence.
        w_state_done = 1'b1;
        w_next_state = ST_RESET_SEQ;
      end
    endcase
  end

  // Sequencing registers; everything holds while ready is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RESET_SEQ;
      r_step       <= 3'd0;
      r_addr_code  <= 3'd0;
      r_op_code    <= 3'd0;
      r_int_is_nmi <= 1'b0;
    end else if (bus.ready) begin
      if (w_state_done) begin
        r_state <= w_next_state;
        r_step  <= 3'd0;
      end else begin
        r_state <= r_state;
        r_step  <= r_step + 3'd1;
      end
      if (r_state == ST_FETCH) begin
        r_addr_code <= bus.addressTimingCode;
        r_op_code   <= bus.opTimingCode;
      end else begin
        r_addr_code <= r_addr_code;
        r_op_code   <= r_op_code;
      end
      if (w_enter_int) begin
        r_int_is_nmi <= w_nmi_pending;
      end else begin
        r_int_is_nmi <= r_int_is_nmi;
      end
    end else begin
      r_state      <= r_state;
      r_step       <= r_step;
      r_addr_code  <= r_addr_code;
      r_op_code    <= r_op_code;
      r_int_is_nmi <= r_int_is_nmi;
    end
  end

  assign bus.seq_state  = seq_state_e'(r_state);
  assign bus.step       = r_step;
  assign bus.sync       = (r_state == ST_FETCH);
  assign bus.instr_done = (r_state == ST_OP) & w_op_last;
  assign bus.int_active = (r_state == ST_INT);
  assign bus.int_is_nmi = r_int_is_nmi;

endmodule
